// File: rtl/mitchell_pkg.sv
// mitchell_pkg: shared widths and the align-stage mantissa builder for the Mitchell antilog decoder
package mitchell_pkg;
  localparam int W = 8;
  localparam int K_W = 4;
  localparam int FRAC_W = 7;
  localparam int CORR_W = 10;
  localparam int MANT_W = 2 + CORR_W;
  // Mantissa in units of 2^-corr_w: 1.f (or the carried f itself) rescaled, plus the LUT correction
  function automatic logic [31:0] s1_mant(input logic [31:0] fsum, input logic [31:0] corr,
                                          input int frac_w, input int corr_w);
    logic [31:0] f;
    f = fsum << (corr_w - frac_w);
    return (fsum[frac_w] ? f : f + (32'd1 << corr_w)) + corr;
  endfunction
endpackage

// File: rtl/mitchell_antilog_shift.sv
// mitchell_antilog_shift: combinational shift (S2) and floor/saturate (S3) datapath
module mitchell_antilog_shift #(
  parameter int W = 8,
  parameter int K_W = 4,
  parameter int CORR_W = 10
) (
  input  logic [K_W:0]                e1,
  input  logic [CORR_W+1:0]           m1,
  output logic [CORR_W+2*W+1:0]       t1,
  input  logic [K_W:0]                e2,
  input  logic [CORR_W+2*W+1:0]       t2,
  output logic [2*W-1:0]              p,
  output logic                        sat
);
  localparam int TW = CORR_W + 2*W + 2;
  logic [2*W+1:0] q;
  assign t1 = TW'(m1) << e1;
  assign q = t2[TW-1:CORR_W];
  assign sat = (e2 >= (K_W+1)'(2*W)) || (|q[2*W+1:2*W]);
  assign p = sat ? '1 : q[2*W-1:0];
endmodule

// File: rtl/mitchell_antilog_decoder.sv
// mitchell_antilog_decoder: 3-stage align/shift/truncate pipeline turning a Mitchell log sum into a linear product
module mitchell_antilog_decoder #(
  parameter int W = mitchell_pkg::W,
  parameter int K_W = mitchell_pkg::K_W,
  parameter int FRAC_W = mitchell_pkg::FRAC_W,
  parameter int CORR_W = mitchell_pkg::CORR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K_W-1:0]    in_k,
  input  logic [FRAC_W:0]   in_fsum,
  input  logic [CORR_W-1:0] in_corr,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_p,
  output logic              out_sat
);
  import mitchell_pkg::*;
  localparam int MW = 2 + CORR_W;
  localparam int TW = MW + 2*W;
  logic v1, v2, v3, adv1, adv2, adv3, z1, z2, sat;
  logic [K_W:0] e1, e2;
  logic [MW-1:0] m1;
  logic [TW-1:0] t1, t2;
  logic [2*W-1:0] p;
  assign adv3 = !v3 || out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign in_ready = adv1;
  assign out_valid = v3;
  mitchell_antilog_shift #(.W(W), .K_W(K_W), .CORR_W(CORR_W)) u_shift (
    .e1(e1), .m1(m1), .t1(t1), .e2(e2), .t2(t2), .p(p), .sat(sat)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_p <= '0;
      out_sat <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        e1 <= (K_W+1)'(in_k) + (K_W+1)'(in_fsum[FRAC_W]);
        m1 <= MW'(s1_mant(32'(in_fsum), 32'(in_corr), FRAC_W, CORR_W));
        z1 <= in_zero;
      end
      if (adv2) begin
        v2 <= v1;
        e2 <= e1;
        t2 <= t1;
        z2 <= z1;
      end
      if (adv3) begin
        v3 <= v2;
        out_p <= z2 ? '0 : p;
        out_sat <= !z2 && sat;
      end
    end
  end
endmodule

// File: tb/tb_mitchell_antilog_decoder.sv
// tb_mitchell_antilog_decoder: randomized scoreboard bench against an arithmetic product model
module tb_mitchell_antilog_decoder;
  import mitchell_pkg::*;
  typedef struct {
    logic [2*W-1:0] p;
    logic sat;
    int acc;
    bit lat;
  } exp_t;

  logic clk = 0, rst = 1, in_valid = 0, in_zero = 0, out_ready = 1;
  logic [K_W-1:0] in_k = '0;
  logic [FRAC_W:0] in_fsum = '0;
  logic [CORR_W-1:0] in_corr = '0;
  logic in_ready, out_valid, out_sat;
  logic [2*W-1:0] out_p;

  exp_t q[$];
  exp_t e_m;
  int tests = 0, fails = 0, ecount = 0, held = 0, full_seen = 0, popped = 0;
  bit acc_f = 0, dr_f = 0, stall = 0, done = 0;
  logic [2*W-1:0] hold_p;

  mitchell_antilog_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k),
    .in_fsum(in_fsum), .in_corr(in_corr), .in_zero(in_zero), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Product = floor(mantissa * 2^E), mantissa = 1.f (or carried f) + corr, all as plain integers
  function automatic exp_t model(int k, int f, int c, bit z);
    exp_t r;
    longint m, pr;
    int e;
    e = k + (f >> FRAC_W);
    m = longint'((f >> FRAC_W) != 0 ? f : f + (1 << FRAC_W)) * (longint'(1) << (CORR_W - FRAC_W))
        + longint'(c);
    pr = m * (longint'(1) << e) / (longint'(1) << CORR_W);
    r.sat = !z && (e >= 2*W || pr >= (longint'(1) << (2*W)));
    r.p = z ? '0 : (r.sat ? '1 : (2*W)'(pr));
    r.acc = 0;
    r.lat = 0;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, ecount);
    end
  endtask

  // Caller is just after a rising edge; returns just after the rising edge that took the beat
  task automatic send(input int k, input int f, input int c, input bit z, input bit lat);
    exp_t r;
    int n;
    in_k = K_W'(k);
    in_fsum = (FRAC_W+1)'(f);
    in_corr = CORR_W'(c);
    in_zero = z;
    in_valid = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        break;
      end
    end
    if (in_ready) begin
      r = model(k, f, c, z);
      r.acc = ecount;
      r.lat = lat;
      q.push_back(r);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d beats pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
  endtask

  always @(posedge clk) begin
    ecount <= ecount + 1;
    held <= rst ? 0 : held + int'(acc_f) - int'(dr_f);
  end

  always @(negedge clk) begin
    if (rst) begin
      stall = 0;
      acc_f = 0;
      dr_f = 0;
    end else begin
      check("in_ready", longint'(in_ready), longint'(!(held == 3 && !out_ready)));
      if (!in_ready) full_seen++;
      if (stall) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_p", longint'(out_p), longint'(hold_p));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got p=%0d expected no output", out_p);
        end else begin
          e_m = q.pop_front();
          popped++;
          check("out_p", longint'(out_p), longint'(e_m.p));
          check("out_sat", longint'(out_sat), longint'(e_m.sat));
          if (e_m.lat) check("latency", longint'(ecount - e_m.acc), 3);
        end
      end
      stall = out_valid && !out_ready;
      hold_p = out_p;
      acc_f = in_valid && in_ready;
      dr_f = out_valid && out_ready;
    end
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_p", longint'(out_p), 0);
    check("rst_sat", longint'(out_sat), 0);
    check("rst_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    send(8, 'h00, 0, 0, 1);
    send(8, 'h80, 0, 0, 1);
    send(8, 'h80, 128, 0, 1);
    send(0, 'h40, 0, 0, 1);
    send(5, int'($urandom_range(0, 255)), int'($urandom_range(0, 1023)), 1, 1);
    send(14, 'hFF, 0, 0, 1);
    send(14, 'hFF, 1023, 0, 1);
    send(15, 'h80, 0, 0, 1);
    send(15, 'hFF, 1023, 1, 1);
    wait_empty();
    full_seen = 0;
    p0 = popped;
    fork
      for (int i = 0; i < 6; i++) send(i + 2, i * 37, i * 150, 0, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    wait_empty();
    check("bp_ready_dropped", longint'(full_seen > 0), 1);
    check("bp_count", longint'(popped - p0), 6);
    out_ready = 0;
    send(3, 'h11, 5, 0, 0);
    send(4, 'h92, 600, 0, 0);
    send(6, 'h33, 9, 0, 0);
    do_reset();
    @(negedge clk);
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_p", longint'(out_p), 0);
    check("mid_rst_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1;
    send(3, 'h55, 77, 0, 1);
    wait_empty();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1023)), $urandom_range(0, 15) == 0, 0);
          repeat (int'($urandom_range(0, 2))) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1;
      end
      while (!done) begin
        out_ready = $urandom_range(0, 3) != 0;
        @(posedge clk);
        #1;
      end
    join
    out_ready = 1;
    wait_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mitchell_antilog_decoder.md
Name: mitchell_antilog_decoder

Overview:
- Decode end of the Mitchell log-domain multiplier: takes the summed log-domain operand (characteristic sum, fraction sum, LUT correction) and produces the linear product.
- Sits after the log encoders and Mitchell_lut; its output is the HETM product.
- 3-stage pipeline with valid/ready handshake and full backpressure.

Parameters:
- W, 8, operand width; the product is 2*W bits.
- K_W, 4, characteristic-sum width; must hold 0..2W-1.
- FRAC_W, 7, fraction width per operand; in_fsum LSB weight is 2^-FRAC_W.
- CORR_W, 10, correction width; in_corr LSB weight is 2^-CORR_W. Requires CORR_W >= FRAC_W.

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, decoder can accept a beat.
- in_k, in, K_W, characteristic sum k1+k2.
- in_fsum, in, FRAC_W+1, fraction sum f1+f2 including carry bit (bit FRAC_W = 1.0).
- in_corr, in, CORR_W, Mitchell_lut correction, unsigned.
- in_zero, in, 1, either operand was zero.
- out_valid, out, 1, product valid.
- out_ready, in, 1, downstream accepts.
- out_p, out, 2W, product.
- out_sat, out, 1, product saturated.

Behaviour:
- Reset: one clock domain (clk); rst is synchronous and active-high. All stage valids clear; out_valid=0, out_p=0, out_sat=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight beats with no partial output.
- Transfer occurs on a clock edge when valid&&ready.
- Latency: exactly 3 cycles from input accept to out_valid when out_ready stays 1. Throughput is 1 beat/cycle.
- Stage advance: stage n loads when stage n is empty or stage n+1 loads/drains that cycle. in_ready = !v1 | adv1. The pipeline holds up to 3 beats.
- Order is preserved. No beat is dropped or duplicated under any out_ready pattern.
- out_p and out_sat hold stable while out_valid && !out_ready.
- S1 (align):
  - c = in_fsum[FRAC_W].
  - E = in_k + c, computed K_W+1 bits wide.
  - Mantissa m, with 2 integer bits and CORR_W fraction bits: m = (c ? in_fsum : 1 + in_fsum), with fsum left-shifted by CORR_W-FRAC_W, then + in_corr.
  - m < 3 always, so no overflow.
- S2 (shift): t = m << E, width 2+CORR_W+2W.
- S3 (truncate/saturate):
  - P = t >> CORR_W (floor).
  - If E >= 2W or P >= 2^(2W): out_p = all ones and out_sat = 1.
  - If in_zero: out_p = 0 and out_sat = 0, overriding all other fields.
- in_k >= 2W-1 is legal input and is handled by the saturation rule.
- Simultaneous out accept and in accept with the pipeline full: both occur and occupancy is unchanged.

Decomposition:
- Package mitchell_pkg: W, K_W, FRAC_W, CORR_W defaults; a derived constant MANT_W = 2+CORR_W; a function computing the S1 mantissa.
- Sub-module mitchell_antilog_shift: combinational S2/S3 datapath (shift, floor, saturate). The pipeline/handshake wrapper stays in the top block.

Test Plan:
- Exact powers: k=8, fsum=0, corr=0, zero=0 -> out_p=256, sat=0, out_valid exactly 3 cycles after accept.
- Carry path with correction: k=8, fsum=8'h80, corr=0 -> 512; same inputs with corr=128 -> 576 (exact 24*24).
- Truncation and zero:
  - k=0, fsum=8'h40, corr=0 -> 1.
  - k=5, zero=1, any fsum/corr -> 0, sat=0.
- Saturation:
  - k=14, fsum=8'hFF, corr=0 -> 65280, sat=0.
  - Same with corr=1023 -> 65535, sat=1.
  - k=15, fsum=8'h80 -> 65535, sat=1.
- Backpressure: stream 6 distinct beats with out_ready low for cycles 2-7.
  - in_ready drops once 3 beats are held.
  - out_p holds stable while stalled.
  - All 6 products emerge in order, none lost or repeated.
- Reset mid-stream: assert rst with 3 beats in flight -> next cycle out_valid=0, out_p=0, in_ready=1; the following beat decodes correctly with 3-cycle latency.
